sdram_pattern_tester: RTL and testbench
=======================================

// Module: sdram_pattern_tester
// PURPOSE
//  Self-checking traffic initiator on the client side of sdram_core's sdram_ctrl_if (drives addr/wr/rd/write_data).
//  Writes an LFSR pattern over a word range, then reads the range back and compares.
//  Used for board bring-up and regression, replacing hand-written bench stimulus.
//  One transaction outstanding at a time. Write phase fully completes before the read phase.
// PARAMETERS
//  ADDR_WIDTH      32    byte-address width of sdram_ctrl_if
//  CNT_WIDTH       24    width of num_words and the word index
//  TIMEOUT_CYCLES  4096  watchdog limit per transaction (used only with SDRAM_TESTER_TIMEOUT_EN)
// PORTS
//  clk              in   1           system clock (same clock as sdram_core)
//  rst_n            in   1           asynchronous active-low reset
//  start            in   1           pulse; sampled in IDLE only
//  base_addr        in   ADDR_WIDTH  byte start address; bits [1:0] are forced to 0
//  num_words        in   CNT_WIDTH   number of 32-bit words to test
//  seed             in   32          LFSR seed; 0 is replaced by 32'h1
//  busy             out  1           test in progress
//  done             out  1           one-cycle pulse at test end
//  pass             out  1           err_count==0 && !timeout; held until the next start
//  err_count        out  16          mismatching reads; saturates at 16'hFFFF
//  first_err_addr   out  ADDR_WIDTH  address of the first mismatch
//  first_err_data   out  32          read data at the first mismatch
//  timeout          out  1           watchdog fired (always 0 without SDRAM_TESTER_TIMEOUT_EN)
//  ctrl_addr        out  ADDR_WIDTH  to sdram_ctrl_if.addr
//  ctrl_wr          out  1           to sdram_ctrl_if.wr
//  ctrl_rd          out  1           to sdram_ctrl_if.rd
//  ctrl_write_data  out  32          to sdram_ctrl_if.write_data
//  ctrl_rdy         in   1           from sdram_ctrl_if.rdy: request accepted
//  ctrl_wvalid      in   1           from sdram_ctrl_if.wvalid: write completed
//  ctrl_rvalid      in   1           from sdram_ctrl_if.rvalid: read_data valid
//  ctrl_read_data   in   32          from sdram_ctrl_if.read_data
// BEHAVIOUR
//  - Reset (async, rst_n=0): every output is 0; state IDLE; ctrl_wr/ctrl_rd drop immediately, including mid-transaction.
//  - States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FIN.
//  - IDLE: start=1 -> latch base/num/seed, clear err_count/first_err_*/timeout/pass, busy=1.
//    Next state is WR_REQ, or FIN if num_words==0.
//  - WR_REQ: ctrl_wr=1, ctrl_addr=base+4*idx, ctrl_write_data=lfsr. At the edge where ctrl_rdy=1 -> WR_WAIT, ctrl_wr=0, write_data=0.
//  - WR_WAIT: ctrl_wvalid=1 -> idx+1 and LFSR advances.
//    If this was the last word (idx==num-1): idx=0, LFSR reloads the seed, next state RD_REQ. Otherwise next state WR_REQ.
//    A wvalid in the same cycle as the rdy that entered WR_WAIT is not counted; wvalid must follow acceptance.
//  - RD_REQ/RD_WAIT mirror the write states with ctrl_rd. On ctrl_rvalid, compare ctrl_read_data against lfsr.
//    On mismatch err_count increments (saturating); the first mismatch also captures first_err_addr/first_err_data.
//    Last word -> FIN.
//  - FIN: done=1 for 1 cycle, busy=0, pass updated, -> IDLE. Status holds until the next start.
//  - Addresses wrap modulo 2^ADDR_WIDTH. Latency: 1 cycle from start to ctrl_wr; 1 cycle from final rvalid to done.
//  - start while busy: ignored. ctrl_rdy/wvalid/rvalid outside the matching state: ignored.
//  - LFSR: 32-bit Galois, taps 32'h80200003, shifts right; advances once per completed word.
// CONFIGURATION
//  - `SDRAM_TESTER_TIMEOUT_EN defined: a 16-bit cycle counter clears on each entry to *_REQ.
//    It counts in *_REQ/*_WAIT. Reaching TIMEOUT_CYCLES -> deassert wr/rd, timeout=1, pass=0, go to FIN.
//  - Not defined: no counter; timeout tied 0; the tester waits indefinitely.
// STRUCTURE
//  - sdram_tester_pkg: state_t enum, LFSR_TAPS, WORD_BYTES=4, function lfsr_next().
//  - Sub-module sdram_lfsr32 (load/seed/advance, state out), instantiated once.
//  - Remainder: FSM and status registers in sdram_pattern_tester.
// TESTING
//  - Bench: sdram_core + MT48LC8M16A2 at 50 MHz, CAS 2. Check the sdram_ctrl_if handshake with assertions.
//  1. base=0x100, num=16, seed=0xACE1 -> 16 writes then 16 reads at 0x100..0x13C.
//     Expect done, pass=1, err_count=0.
//  2. num=0 -> done 1 cycle after start; pass=1; ctrl_wr/ctrl_rd never asserted.
//  3. Bench flips bit 0 of read_data on word 3, base=0x2000 -> err_count=1, first_err_addr=0x200C, pass=0.
//  4. base=0xFFFFFFF8, num=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; pass=1.
//  5. rst_n low during RD_WAIT -> all outputs 0 asynchronously; a new start then runs a clean pass.
//  6. With SDRAM_TESTER_TIMEOUT_EN and ctrl_rdy forced 0 -> timeout=1 at TIMEOUT_CYCLES, done pulse, pass=0.
//     Without the macro -> busy stays 1.

Source files
------------

// File: rtl/sdram_tester_pkg.sv
// Shared types and LFSR helper for the SDRAM pattern tester.
// State encoding, tap constant and word size used by tester modules.
package sdram_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    FIN
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/sdram_lfsr32.sv
// 32-bit Galois LFSR pattern source for the SDRAM tester.
// Load takes priority over advance; advance steps once per word.
module sdram_lfsr32
  import sdram_tester_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  // pattern register: reload on load, shift right on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 32'h1;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// Write-then-read LFSR pattern tester on the sdram_ctrl_if client side.
// Optional per-transaction watchdog: define SDRAM_TESTER_TIMEOUT_EN.
module sdram_pattern_tester
  import sdram_tester_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [31:0]           first_err_data,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic                  ctrl_wr,
  output logic                  ctrl_rd,
  output logic [31:0]           ctrl_write_data,
  input  logic                  ctrl_rdy,
  input  logic                  ctrl_wvalid,
  input  logic                  ctrl_rvalid,
  input  logic [31:0]           ctrl_read_data
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] base_in;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  idx;
  logic [31:0]           seed_q;
  logic [31:0]           seed_in;
  logic [31:0]           lfsr_q;
  logic [31:0]           lfsr_seed;
  logic                  lfsr_load;
  logic                  lfsr_adv;
  logic                  last;
  logic                  mis;
  logic                  tmo_fire;
  logic [15:0]           err_nxt;

  assign base_in  = {base_addr[ADDR_WIDTH-1:2], 2'b00};
  assign seed_in  = (seed == 32'h0) ? 32'h1 : seed;
  assign last     = (idx == num_q - CNT_WIDTH'(1));
  assign addr_nxt = base_q
                  + ADDR_WIDTH'(idx + CNT_WIDTH'(1))
                  * ADDR_WIDTH'(WORD_BYTES);
  assign mis      = (ctrl_read_data != lfsr_q);
  assign err_nxt  = (mis && err_count != 16'hFFFF)
                  ? err_count + 16'd1 : err_count;

  sdram_lfsr32 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .seed    (lfsr_seed),
    .advance (lfsr_adv),
    .state   (lfsr_q)
  );

  // pattern sequencing: seed at start and again for the read pass
  always_comb begin
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    lfsr_seed = seed_q;
    unique case (1'b1)
      (state == IDLE) && start: begin
        lfsr_load = 1'b1;
        lfsr_seed = seed_in;
      end
      (state == WR_WAIT) && ctrl_wvalid && last:
        lfsr_load = 1'b1;
      ((state == WR_WAIT) && ctrl_wvalid && !last) ||
      ((state == RD_WAIT) && ctrl_rvalid):
        lfsr_adv = 1'b1;
      default: ;
    endcase
  end

`ifdef SDRAM_TESTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        in_xfer;
  logic        enter_req;

  assign in_xfer   = (state == WR_REQ) || (state == WR_WAIT) ||
                     (state == RD_REQ) || (state == RD_WAIT);
  assign enter_req = ((state == IDLE) && start) ||
                     ((state == WR_WAIT) && ctrl_wvalid) ||
                     ((state == RD_WAIT) && ctrl_rvalid && !last);
  assign tmo_fire  = in_xfer &&
                     (tmo_cnt >= 16'(TIMEOUT_CYCLES - 1));

  // cycles spent on the current transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 16'd0;
    end else if (enter_req) begin
      tmo_cnt <= 16'd0;
    end else if (in_xfer) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  // limit is unused when the watchdog is compiled out
  assign tmo_fire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // test sequencer with registered bus and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      base_q          <= '0;
      num_q           <= '0;
      idx             <= '0;
      seed_q          <= 32'h0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= 16'd0;
      first_err_addr  <= '0;
      first_err_data  <= 32'h0;
      timeout         <= 1'b0;
      ctrl_addr       <= '0;
      ctrl_wr         <= 1'b0;
      ctrl_rd         <= 1'b0;
      ctrl_write_data <= 32'h0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q         <= base_in;
            num_q          <= num_words;
            seed_q         <= seed_in;
            idx            <= '0;
            err_count      <= 16'd0;
            first_err_addr <= '0;
            first_err_data <= 32'h0;
            timeout        <= 1'b0;
            if (num_words == '0) begin
              pass  <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              pass            <= 1'b0;
              busy            <= 1'b1;
              ctrl_wr         <= 1'b1;
              ctrl_addr       <= base_in;
              ctrl_write_data <= seed_in;
              state           <= WR_REQ;
            end
          end
        end
        WR_REQ, WR_WAIT, RD_REQ, RD_WAIT: begin
          if ((state == WR_REQ) && ctrl_rdy) begin
            ctrl_wr         <= 1'b0;
            ctrl_write_data <= 32'h0;
            state           <= WR_WAIT;
          end else if ((state == RD_REQ) && ctrl_rdy) begin
            ctrl_rd <= 1'b0;
            state   <= RD_WAIT;
          end else if ((state == WR_WAIT) && ctrl_wvalid) begin
            if (last) begin
              idx       <= '0;
              ctrl_rd   <= 1'b1;
              ctrl_addr <= base_q;
              state     <= RD_REQ;
            end else begin
              idx             <= idx + CNT_WIDTH'(1);
              ctrl_wr         <= 1'b1;
              ctrl_addr       <= addr_nxt;
              ctrl_write_data <= lfsr_next(lfsr_q);
              state           <= WR_REQ;
            end
          end else if ((state == RD_WAIT) && ctrl_rvalid) begin
            err_count <= err_nxt;
            if (mis && err_count == 16'd0) begin
              first_err_addr <= ctrl_addr;
              first_err_data <= ctrl_read_data;
            end
            if (last) begin
              pass  <= (err_nxt == 16'd0);
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              idx       <= idx + CNT_WIDTH'(1);
              ctrl_rd   <= 1'b1;
              ctrl_addr <= addr_nxt;
              state     <= RD_REQ;
            end
          end else if (tmo_fire) begin
            ctrl_wr         <= 1'b0;
            ctrl_rd         <= 1'b0;
            ctrl_write_data <= 32'h0;
            timeout         <= 1'b1;
            pass            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b1;
            state           <= FIN;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: SDRAM responder, pattern model, checks.
// Watchdog path exercised when SDRAM_TESTER_TIMEOUT_EN is defined.
module tb_sdram_pattern_tester;

  localparam int AW = 32;
  localparam int CW = 24;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_words = '0;
  logic [31:0]   seed = 32'h0;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr, ctrl_addr;
  logic [31:0]   first_err_data, ctrl_write_data;
  logic          ctrl_wr, ctrl_rd;
  logic          ctrl_rdy, ctrl_wvalid, ctrl_rvalid;
  logic [31:0]   ctrl_read_data;

  int checks = 0;
  int errors = 0;

  sdram_pattern_tester #(
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .num_words(num_words), .seed(seed),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_data(first_err_data), .timeout(timeout),
    .ctrl_addr(ctrl_addr), .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd),
    .ctrl_write_data(ctrl_write_data), .ctrl_rdy(ctrl_rdy),
    .ctrl_wvalid(ctrl_wvalid), .ctrl_rvalid(ctrl_rvalid),
    .ctrl_read_data(ctrl_read_data)
  );

  initial forever #10 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got hang, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ TAPS;
    return r;
  endfunction

  // model state
  logic [AW-1:0] exp_wa[$], exp_ra[$], obs_wa[$];
  logic [31:0]   exp_wd[$], obs_wd[$];
  logic          exp_pass, exp_tmo, any_req;
  logic [15:0]   exp_err;
  logic [AW-1:0] exp_fa;
  logic [31:0]   exp_fd;
  int            done_seen;

  // responder knobs
  logic          rdy_block = 1'b0;
  logic          flip_en = 1'b0;
  logic [AW-1:0] flip_addr = '0;
  int            lat = 1;
  int            gap = 0;
  logic [31:0]   mem [logic [AW-1:0]];

  // SDRAM controller stand-in: accept, then complete after lat cycles
  initial begin
    int            dly, gdly;
    logic          pend, pwr;
    logic [AW-1:0] pa;
    logic [31:0]   rd;
    dly = 0; gdly = 0; pend = 1'b0; pwr = 1'b0; pa = '0;
    ctrl_rdy = 1'b0; ctrl_wvalid = 1'b0; ctrl_rvalid = 1'b0;
    ctrl_read_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      ctrl_rdy = 1'b0; ctrl_wvalid = 1'b0; ctrl_rvalid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
        gdly = gap;
      end else if (pend) begin
        if (dly > 0) dly--;
        else begin
          pend = 1'b0;
          if (pwr) ctrl_wvalid = 1'b1;
          else begin
            rd = mem.exists(pa) ? mem[pa] : 32'h0;
            if (flip_en && pa == flip_addr) rd[0] = ~rd[0];
            ctrl_read_data = rd;
            ctrl_rvalid = 1'b1;
          end
        end
      end else if (!rdy_block && (ctrl_wr || ctrl_rd)) begin
        if (gdly > 0) gdly--;
        else begin
          ctrl_rdy = 1'b1;
          pend = 1'b1;
          pwr = ctrl_wr;
          pa = ctrl_addr;
          dly = lat;
          gdly = gap;
          if (ctrl_wr) mem[pa] = ctrl_write_data;
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("wr_rd_excl", 64'(ctrl_wr & ctrl_rd), 0);
      if (ctrl_wr || ctrl_rd) any_req = 1'b1;
      if (ctrl_wr && ctrl_rdy) begin
        obs_wa.push_back(ctrl_addr);
        obs_wd.push_back(ctrl_write_data);
        if (exp_wa.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("wr_addr", ctrl_addr, exp_wa.pop_front());
          chk("wr_data", ctrl_write_data, exp_wd.pop_front());
        end
      end
      if (ctrl_rd && ctrl_rdy) begin
        if (exp_ra.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", ctrl_addr, exp_ra.pop_front());
      end
      if (done) begin
        done_seen++;
        chk("done_pass", pass, exp_pass);
        chk("done_err", err_count, exp_err);
        chk("done_fea", first_err_addr, exp_fa);
        chk("done_fed", first_err_data, exp_fd);
        chk("done_tmo", timeout, exp_tmo);
        chk("done_busy", busy, 0);
      end
    end
  end

  task automatic prep(input logic [AW-1:0] b, input int n,
                      input logic [31:0] s, input bit fl,
                      input int fw, input int l, input int g);
    logic [31:0]   v;
    logic [AW-1:0] a0, a;
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    obs_wa.delete(); obs_wd.delete();
    lat = l; gap = g; flip_en = fl;
    a0 = {b[AW-1:2], 2'b00};
    flip_addr = a0 + AW'(4 * fw);
    v = (s == 32'h0) ? 32'h1 : s;
    exp_err = 16'd0; exp_fa = '0; exp_fd = 32'h0; exp_tmo = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = a0 + AW'(4 * i);
      exp_wa.push_back(a);
      exp_wd.push_back(v);
      exp_ra.push_back(a);
      if (fl && i == fw) begin
        exp_err = 16'd1; exp_fa = a; exp_fd = v ^ 32'h1;
      end
      v = model_step(v);
    end
    exp_pass = (exp_err == 16'd0);
    done_seen = 0;
    any_req = 1'b0;
    base_addr = b; num_words = CW'(n); seed = s;
  endtask

  task automatic kick(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) chk("lat_done", done, 1);
    else chk("lat_wr", ctrl_wr, 1);
  endtask

  task automatic finish(input int lim);
    for (int i = 0; i < lim && !done; i++) @(negedge clk);
    chk("done_reached", done, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("done_count", done_seen, 1);
    chk("pass_hold", pass, exp_pass);
    chk("busy_after", busy, 0);
    chk("wr_left", exp_wa.size(), 0);
    chk("rd_left", exp_ra.size(), 0);
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_flags"},
        {busy, done, pass, timeout, ctrl_wr, ctrl_rd, err_count}, 0);
    chk({t, "_fea"}, first_err_addr, 0);
    chk({t, "_fed"}, first_err_data, 0);
    chk({t, "_addr"}, ctrl_addr, 0);
    chk({t, "_wdata"}, ctrl_write_data, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // basic run
    prep(32'h100, 16, 32'hACE1, 0, 0, 1, 0);
    kick(16);
    finish(2000);
    chk("t1_wd0", obs_wd[0], 32'h0000ACE1);
    chk("t1_wd1", obs_wd[1], 32'h80205673);
    chk("t1_wa15", obs_wa[15], 32'h13C);
    chk("t1_pass", {pass, err_count}, {1'b1, 16'd0});

    // empty range
    prep(32'h40, 0, 32'h1234, 0, 0, 1, 0);
    kick(0);
    finish(10);
    chk("t2_noreq", any_req, 0);
    chk("t2_pass", pass, 1);

    // single bit error on word 3
    prep(32'h2000, 16, 32'h5EED, 1, 3, 2, 1);
    kick(16);
    finish(3000);
    chk("t3_err", err_count, 1);
    chk("t3_fea", first_err_addr, 32'h200C);
    chk("t3_pass", pass, 0);

    // address wrap, unaligned base bits ignored
    prep(32'hFFFFFFFB, 4, 32'hDEADBEEF, 0, 0, 0, 2);
    kick(4);
    finish(1000);
    chk("t4_wa0", obs_wa[0], 32'hFFFFFFF8);
    chk("t4_wa2", obs_wa[2], 32'h0);
    chk("t4_wa3", obs_wa[3], 32'h4);
    chk("t4_pass", pass, 1);

    // zero seed behaves as seed 1
    prep(32'h800, 3, 32'h0, 0, 0, 3, 0);
    kick(3);
    finish(1000);
    chk("t4b_wd0", obs_wd[0], 32'h1);

    // async reset while waiting on a read
    prep(32'h3000, 8, 32'h1234, 0, 0, 6, 0);
    kick(8);
    for (int i = 0; i < 2000 && !ctrl_rd; i++) @(negedge clk);
    chk("t5_rd_seen", ctrl_rd, 1);
    for (int i = 0; i < 50 && ctrl_rd; i++) @(negedge clk);
    chk("t5_rd_taken", ctrl_rd, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t5_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    prep(32'h3000, 8, 32'h1234, 0, 0, 1, 1);
    kick(8);
    finish(2000);
    chk("t5_pass", pass, 1);

    // controller never accepts
    prep(32'h500, 4, 32'h77, 0, 0, 1, 0);
    rdy_block = 1'b1;
`ifdef SDRAM_TESTER_TIMEOUT_EN
    exp_pass = 1'b0;
    exp_tmo = 1'b1;
    kick(4);
    for (int i = 0; i < 5000 && !done; i++) @(negedge clk);
    chk("t6_done", done, 1);
    @(posedge clk); #1;
    chk("t6_tmo", {timeout, pass, ctrl_wr}, {1'b1, 1'b0, 1'b0});
`else
    kick(4);
    repeat (300) @(negedge clk);
    chk("t6_busy", busy, 1);
    chk("t6_nodone", done_seen, 0);
    chk("t6_tmo", timeout, 0);
`endif
    rst_n = 1'b0;
    rdy_block = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
